// File: rtl/shift_cmd_issue_if.sv
// Command, shifter and result signals of the shift command-issue stage.
// master = command source / result sink / shifter; slave = the issue stage.
interface shift_cmd_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic        in_dir;
  logic        in_type;
  logic [3:0]  in_tag;

  logic [15:0] sh_data_in;
  logic [3:0]  sh_shift_amount;
  logic        sh_direction;
  logic        sh_type;
  logic [15:0] sh_data_out;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_tag;
  logic        out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_dir, in_type, in_tag,
    input  in_ready,
    input  sh_data_in, sh_shift_amount, sh_direction, sh_type,
    output sh_data_out,
    input  out_valid, out_data, out_tag, out_zero,
    output out_ready
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_dir, in_type, in_tag,
    output in_ready,
    output sh_data_in, sh_shift_amount, sh_direction, sh_type,
    input  sh_data_out,
    output out_valid, out_data, out_tag, out_zero,
    input  out_ready
  );
endinterface

// File: rtl/shift_cmd_issue.sv
// Command FIFO in front of a combinational barrel shifter, with a registered,
// back-pressurable result stage behind it. One command per cycle sustained.
module shift_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  shift_cmd_issue_if.slave         bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         done_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 26;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Entry layout: {data[25:10], shamt[9:6], dir[5], type[4], tag[3:0]}
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic             r_out_valid;
  logic [15:0]      r_out_data;
  logic [3:0]       r_out_tag;
  logic             r_out_zero;
  logic [CNT_W-1:0] r_done;

  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_hs;
  logic             w_nonempty;
  logic [EW-1:0]    w_head;

  // Ready depends only on occupancy and reset, never on out_ready.
  assign w_nonempty = (r_count != '0);
  assign w_in_ready = !rst && (r_count < DEPTH_C);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_pop      = !rst && w_nonempty && (!r_out_valid || bus.out_ready);
  assign w_hs       = !rst && r_out_valid && bus.out_ready;

  always_comb begin
    w_head = '0;
    if (w_nonempty) begin
      w_head = r_mem[r_rd_ptr];
    end
  end

  assign bus.in_ready        = w_in_ready;
  assign bus.sh_data_in      = w_head[25:10];
  assign bus.sh_shift_amount = w_head[9:6];
  assign bus.sh_direction    = w_head[5];
  assign bus.sh_type         = w_head[4];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_data, bus.in_shamt, bus.in_dir, bus.in_type, bus.in_tag};
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.sh_data_out;
      r_out_tag   <= w_head[3:0];
      r_out_zero  <= (bus.sh_data_out == 16'h0000);
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= '0;
    end else if (w_hs && (r_done != '1)) begin
      r_done <= r_done + CNT_W'(1);
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_zero  = r_out_zero;
  assign fifo_count    = r_count;
  assign done_count    = r_done;
endmodule

// File: tb/tb_shift_cmd_issue.sv
// Directed + randomized bench for shift_cmd_issue with a queue-based reference model.
module tb_shift_cmd_issue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_cmd_issue_if bus ();
  shift_cmd_issue_if bus4 ();

  logic [2:0]  fifo_count;
  logic [2:0]  fifo_count4;
  logic [15:0] done_count;
  logic [3:0]  done4;

  shift_cmd_issue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .fifo_count(fifo_count), .done_count(done_count)
  );

  shift_cmd_issue #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .fifo_count(fifo_count4), .done_count(done4)
  );

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.in_shamt  = bus.in_shamt;
  assign bus4.in_dir    = bus.in_dir;
  assign bus4.in_type   = bus.in_type;
  assign bus4.in_tag    = bus.in_tag;
  assign bus4.out_ready = bus.out_ready;

  // Stand-in for the external combinational shifter.
  function automatic logic [15:0] hw_shift(input logic [15:0] d, input logic [3:0] s,
                                           input logic dir, input logic typ);
    logic signed [15:0] sd;
    sd = d;
    if (dir) return d << s;
    if (typ) return 16'(sd >>> s);
    return d >> s;
  endfunction

  always_comb bus.sh_data_out  = hw_shift(bus.sh_data_in, bus.sh_shift_amount,
                                          bus.sh_direction, bus.sh_type);
  always_comb bus4.sh_data_out = hw_shift(bus4.sh_data_in, bus4.sh_shift_amount,
                                          bus4.sh_direction, bus4.sh_type);

  // Reference result from plain arithmetic: multiply/divide by 2^s.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s,
                                            input logic dir, input logic typ);
    int unsigned v;
    int unsigned p;
    v = d;
    p = 1 << s;
    if (dir) return 16'((v * p) % 65536);
    if (typ && d[15]) return 16'(65535 - (65535 - v) / p);
    return 16'(v / p);
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int hs = 0;
  int acc = 0;

  logic [15:0] d2 [4];
  logic [3:0]  s2 [4];
  logic        dir2 [4];
  logic        t2 [4];
  logic [15:0] e2 [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [3:0] s, input logic dir,
                       input logic typ, input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_dir   = dir;
    bus.in_type  = typ;
    bus.in_tag   = tag;
  endtask

  task automatic drive_rand();
    drive(16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom % 2),
          1'($urandom % 2), 4'($urandom % 16));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock: update the model from the handshakes about to happen, then advance.
  task automatic step();
    exp_t e;
    #1;
    if (rst) begin
      exp_q.delete();
      hs = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{ref_shift(bus.in_data, bus.in_shamt, bus.in_dir, bus.in_type),
                          bus.in_tag});
        acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("hs_data", bus.out_data, e.data);
          chk("hs_tag", bus.out_tag, e.tag);
          chk("hs_zero", bus.out_zero, 32'(e.data == 16'h0));
        end
        hs++;
      end
    end
    @(posedge clk);
    #1;
    chk("done_count", done_count, (hs > 65535) ? 65535 : hs);
    chk("done4", done4, (hs > 15) ? 15 : hs);
  endtask

  initial begin
    logic [15:0] held_data;
    logic [3:0]  held_tag;
    logic        held;

    d2   = '{16'h8000, 16'h8000, 16'h00F0, 16'h0001};
    s2   = '{4'd15, 4'd15, 4'd4, 4'd1};
    dir2 = '{1'b0, 1'b0, 1'b1, 1'b0};
    t2   = '{1'b1, 1'b0, 1'b1, 1'b0};
    e2   = '{16'hFFFF, 16'h0001, 16'h0F00, 16'h0000};

    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(16'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    idle();
    step();
    step();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_zero", bus.out_zero, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_sh_data", bus.sh_data_in, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Single command, two-cycle latency.
    bus.out_ready = 1'b1;
    drive(16'h8001, 4'd1, 1'b1, 1'b0, 4'd3);
    step();
    idle();
    chk("t1_fifo_count", fifo_count, 1);
    chk("t1_sh_data", bus.sh_data_in, 16'h8001);
    chk("t1_sh_amt", bus.sh_shift_amount, 1);
    chk("t1_sh_dir", bus.sh_direction, 1);
    chk("t1_out_valid_early", bus.out_valid, 0);
    step();
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_data", bus.out_data, 16'h0002);
    chk("t1_out_tag", bus.out_tag, 3);
    chk("t1_out_zero", bus.out_zero, 0);
    step();
    chk("t1_done", done_count, 1);
    chk("t1_out_valid_clr", bus.out_valid, 0);

    // Back-to-back, no bubbles.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(d2[i], s2[i], dir2[i], t2[i], 4'(4 + i));
      else idle();
      step();
      if (i >= 1 && i <= 4) begin
        chk("t2_out_valid", bus.out_valid, 1);
        chk("t2_out_data", bus.out_data, e2[i-1]);
        chk("t2_out_zero", bus.out_zero, 32'(e2[i-1] == 16'h0));
      end
    end

    // Back-pressure: DEPTH+1 accepted, output stable.
    bus.out_ready = 1'b0;
    acc = 0;
    held = 1'b0;
    held_data = '0;
    held_tag = '0;
    for (int i = 0; i < 10; i++) begin
      drive_rand();
      step();
      if (held) begin
        chk("t3_stable_data", bus.out_data, held_data);
        chk("t3_stable_tag", bus.out_tag, held_tag);
      end else if (bus.out_valid) begin
        held = 1'b1;
        held_data = bus.out_data;
        held_tag = bus.out_tag;
      end
    end
    chk("t3_accepted", acc, DEPTH + 1);
    chk("t3_in_ready", bus.in_ready, 0);
    chk("t3_fifo_count", fifo_count, DEPTH);
    chk("t3_out_valid", bus.out_valid, 1);
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t3_drain_valid", bus.out_valid, 1);
      step();
    end
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_out_valid_end", bus.out_valid, 0);

    // Simultaneous push/pop at count 3 and 1, then random traffic.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    chk("t4_count3", fifo_count, 3);
    bus.out_ready = 1'b1;
    drive_rand();
    step();
    chk("t4_pp_count3", fifo_count, 3);
    idle();
    step();
    step();
    chk("t4_count1", fifo_count, 1);
    drive_rand();
    step();
    chk("t4_pp_count1", fifo_count, 1);
    acc = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom % 4 != 0) drive_rand();
      else idle();
      bus.out_ready = ($urandom % 4 != 0);
      step();
    end
    chk("t4_enough_cmds", 32'(acc >= 3 * DEPTH), 1);
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_fifo_empty", fifo_count, 0);
    chk("t4_out_valid", bus.out_valid, 0);

    // Reset mid-operation.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    chk("t5_pre_count", fifo_count, 3);
    chk("t5_pre_valid", bus.out_valid, 1);
    rst = 1'b1;
    drive_rand();
    #1;
    chk("t5_in_ready_rst", bus.in_ready, 0);
    step();
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_fifo_count", fifo_count, 0);
    chk("t5_done", done_count, 0);
    chk("t5_sh_data", bus.sh_data_in, 0);
    chk("t5_sh_amt", bus.sh_shift_amount, 0);
    chk("t5_sh_dir", bus.sh_direction, 0);
    chk("t5_sh_type", bus.sh_type, 0);
    rst = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    step();
    step();
    chk("t5_no_stale", bus.out_valid, 0);

    // Saturating counter on the narrow build.
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      bus.out_ready = ($urandom % 8 != 0);
      step();
    end
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("t6_enough_hs", 32'(hs >= 20), 1);
    chk("t6_done4_sat", done4, 15);
    chk("t6_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
